rect_fill_engine: RTL
=====================

Name: rect_fill_engine

Overview:
Upstream feeder for the VGA pixel stage's 640x480 8-bit frame memory write port. A software-programmed rectangle fill: the CPU loads the origin, size and colour through Avalon-MM registers, then issues a start command. The engine clips the rectangle to the screen and streams one framebuffer write per accepted cycle, row-major, at the linear address y*640+x. It replaces the per-pixel CPU address/data writes with a bulk fill.

Parameters:
HRES, 640, active pixels per line; also the row stride.
VRES, 480, active lines.
AW, 19, framebuffer address width (must satisfy 2^AW >= HRES*VRES).

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset (0 = reset)
chipselect  input  1  Avalon slave select
write  input  1  Avalon write strobe
read  input  1  Avalon read strobe
address  input  4  register index
writedata  input  8  register write data
readdata  output  8  register read data, registered
fb_addr  output  AW  framebuffer write address
fb_data  output  8  framebuffer write pixel
fb_write  output  1  write request
fb_ready  input  1  frame memory accepts the write this cycle
busy  output  1  engine active
done  output  1  one-cycle pulse when a fill completes

Behaviour:
- Register map (write): 0 X_HI[1:0], 1 X_LO, 2 Y_HI[1:0], 3 Y_LO, 4 W_HI[1:0], 5 W_LO, 6 H_HI[1:0], 7 H_LO, 8 COLOR, 9 CTRL (any write = start). Addresses 10-15: writes are ignored.
- Field widths: x, y, w and h are 10 bits each ({HI[1:0], LO}). Unused HI bits are ignored.
- Reads: 0-8 return the shadow values (HI zero-extended). 9 returns {7'b0, busy}. 10-15 return 0. readdata updates on the clock after read&&chipselect.
- Shadow registers are writable at any time. The engine latches them only on an accepted start.
- Reset (reset=0, async): all shadows = 0; state IDLE; fb_write = 0; fb_addr = 0; fb_data = 0; busy = 0; done = 0; readdata = 0.
- Reset mid-fill aborts immediately. No done pulse is produced.
- State machine IDLE -> SETUP -> FILL -> DONE -> IDLE.
- IDLE: a CTRL write moves the engine to SETUP on the next edge. A CTRL write while not IDLE is ignored, with no queuing.
- SETUP (1 cycle): latch the colour and compute the clipped rectangle.
  - x_end = min(x+w, HRES); y_end = min(y+h, VRES). Use 11-bit sums, no wrap.
  - row_base = y*HRES, computed as shift-add (y<<9 + y<<7). No multiplier.
  - If w==0, h==0, x>=HRES or y>=VRES, go straight to DONE with zero writes. Otherwise go to FILL with col=x, row=y.
- FILL:
  - fb_write=1, fb_addr=row_base+col, fb_data=colour.
  - Signals hold stable while fb_ready=0 (stall with no advance).
  - On fb_write&&fb_ready: col++. If col+1==x_end then col=x, row++ and row_base+=HRES.
  - If that was also the last row (row+1==y_end), go to DONE. fb_write deasserts the following cycle.
- DONE (1 cycle): done=1, then IDLE.
- busy=1 in SETUP, FILL and DONE.
- Latency: CTRL write sampled at edge N; SETUP in cycle N+1; first fb_write in cycle N+2.
- Throughput: with fb_ready held high, one pixel per clock. Total writes = (x_end-x)*(y_end-y).
- Addresses never exceed HRES*VRES-1.

Test Plan:
- Basic fill: x=10, y=5, w=3, h=2, COLOR=8'hAA, start, fb_ready=1 -> 6 writes at 3210, 3211, 3212, 3850, 3851, 3852, all data AA. The first write is 2 cycles after start, and a done pulse follows the last write.
- Clipping: x=638, y=479, w=5, h=4 -> exactly 2 writes at 307198 and 307199, then done.
- Degenerate cases: w=0; separately x=700 -> zero fb_write cycles, busy high for 2 cycles (SETUP, DONE), one done pulse.
- Backpressure: 4x1 fill with fb_ready toggling 1,0,0,1,1,0,1 -> fb_addr/fb_data hold during stalls, 4 accepted writes in order, no duplicates or skips.
- Busy interlock: start a 640x480 fill; mid-fill write COLOR=8'h11 and CTRL -> the fill continues with the original colour and 307200 total writes. Status read at address 9 returns 1 during the fill and 0 after done.
- Async reset: assert reset=0 between edges mid-fill -> fb_write, busy and done drop immediately without waiting for a clock edge. After release, the shadows read 0 and a new start works normally.

Source files
------------

// File: rtl/rect_fill_engine_if.sv
// Bus bundle for the rectangle fill engine: Avalon-MM register port,
// framebuffer write port and engine status.
interface rect_fill_engine_if #(
    parameter int AW = 19
);
    logic          chipselect;
    logic          write;
    logic          read;
    logic [3:0]    address;
    logic [7:0]    writedata;
    logic [7:0]    readdata;
    logic [AW-1:0] fb_addr;
    logic [7:0]    fb_data;
    logic          fb_write;
    logic          fb_ready;
    logic          busy;
    logic          done;

    // Engine side: Avalon slave, framebuffer write master
    modport slave (
        input  chipselect, write, read, address, writedata, fb_ready,
        output readdata, fb_addr, fb_data, fb_write, busy, done
    );

    // CPU / frame memory side
    modport master (
        output chipselect, write, read, address, writedata, fb_ready,
        input  readdata, fb_addr, fb_data, fb_write, busy, done
    );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: CPU-programmed origin/size/colour, clipped to the
// screen, streamed as row-major framebuffer writes at y*HRES+x.
module rect_fill_engine #(
    parameter int HRES = 640,
    parameter int VRES = 480,
    parameter int AW   = 19
) (
    input  logic          clk,
    input  logic          reset,
    rect_fill_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

    localparam logic [10:0]   HRES_W = 11'(HRES);
    localparam logic [10:0]   VRES_W = 11'(VRES);
    localparam logic [AW-1:0] STRIDE = AW'(HRES);

    state_t        state_q, state_d;

    logic [1:0]    x_hi, y_hi, w_hi, h_hi;
    logic [7:0]    x_lo, y_lo, w_lo, h_lo, color_sh;

    logic [9:0]    x_l, y_l, w_l, h_l;
    logic [7:0]    color_l;
    logic [9:0]    col, row;
    logic [10:0]   x_end, y_end;
    logic [AW-1:0] row_base;
    logic [AW-1:0] y_ext;
    logic [10:0]   x_sum, y_sum;

    logic [7:0]    rd_mux, rd_q;
    logic          reg_wr, start, accept, last_col, last_row, empty;
    logic          fb_write_c, busy_c, done_c;

    assign reg_wr   = bus.chipselect && bus.write;
    assign start    = reg_wr && (bus.address == 4'd9) && (state_q == IDLE);
    assign accept   = (state_q == FILL) && bus.fb_ready;
    assign last_col = ({1'b0, col} + 11'd1) == x_end;
    assign last_row = ({1'b0, row} + 11'd1) == y_end;
    assign x_sum    = {1'b0, x_l} + {1'b0, w_l};
    assign y_sum    = {1'b0, y_l} + {1'b0, h_l};
    assign y_ext    = {{(AW-10){1'b0}}, y_l};
    assign empty    = (w_l == '0) || (h_l == '0) ||
                      ({1'b0, x_l} >= HRES_W) || ({1'b0, y_l} >= VRES_W);

    // Shadow registers, writable at any time
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_hi <= '0; x_lo <= '0; y_hi <= '0; y_lo <= '0;
            w_hi <= '0; w_lo <= '0; h_hi <= '0; h_lo <= '0;
            color_sh <= '0;
        end else if (reg_wr) begin
            case (bus.address)
                4'd0: x_hi <= bus.writedata[1:0];
                4'd1: x_lo <= bus.writedata;
                4'd2: y_hi <= bus.writedata[1:0];
                4'd3: y_lo <= bus.writedata;
                4'd4: w_hi <= bus.writedata[1:0];
                4'd5: w_lo <= bus.writedata;
                4'd6: h_hi <= bus.writedata[1:0];
                4'd7: h_lo <= bus.writedata;
                4'd8: color_sh <= bus.writedata;
                default: ;
            endcase
        end
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            4'd0: rd_mux = {6'b0, x_hi};
            4'd1: rd_mux = x_lo;
            4'd2: rd_mux = {6'b0, y_hi};
            4'd3: rd_mux = y_lo;
            4'd4: rd_mux = {6'b0, w_hi};
            4'd5: rd_mux = w_lo;
            4'd6: rd_mux = {6'b0, h_hi};
            4'd7: rd_mux = h_lo;
            4'd8: rd_mux = color_sh;
            4'd9: rd_mux = {7'b0, busy_c};
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, updated only on a selected read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (bus.chipselect && bus.read) begin
            rd_q <= rd_mux;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and status outputs
    always_comb begin
        state_d    = state_q;
        fb_write_c = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (start) state_d = SETUP;
            end
            SETUP: state_d = empty ? DONE : FILL;
            FILL: begin
                fb_write_c = 1'b1;
                if (accept && last_col && last_row) state_d = DONE;
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Rectangle latch on start, clip/setup, and raster walk on accepted writes.
    // Parameters are captured at the start edge so shadow writes during SETUP
    // cannot leak into the fill; row_base = y*640 as (y<<9)+(y<<7).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_l <= '0; y_l <= '0; w_l <= '0; h_l <= '0; color_l <= '0;
            x_end <= '0; y_end <= '0; row_base <= '0; col <= '0; row <= '0;
        end else begin
            if (start) begin
                x_l     <= {x_hi, x_lo};
                y_l     <= {y_hi, y_lo};
                w_l     <= {w_hi, w_lo};
                h_l     <= {h_hi, h_lo};
                color_l <= color_sh;
            end
            if (state_q == SETUP) begin
                x_end    <= (x_sum > HRES_W) ? HRES_W : x_sum;
                y_end    <= (y_sum > VRES_W) ? VRES_W : y_sum;
                row_base <= (y_ext << 9) + (y_ext << 7);
                col      <= x_l;
                row      <= y_l;
            end else if (accept) begin
                if (last_col) begin
                    col      <= x_l;
                    row      <= row + 10'd1;
                    row_base <= row_base + STRIDE;
                end else begin
                    col <= col + 10'd1;
                end
            end
        end
    end

    assign bus.readdata = rd_q;
    assign bus.fb_write = fb_write_c;
    assign bus.fb_addr  = fb_write_c ? (row_base + {{(AW-10){1'b0}}, col}) : '0;
    assign bus.fb_data  = fb_write_c ? color_l : '0;
    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
endmodule
